// File: rtl/softmax_pkg.sv
// Shared formats, FSM state type and the exp() lookup table for the streaming softmax.
// The table is built at elaboration with exact integer fixed-point arithmetic.
package softmax_pkg;

  localparam int unsigned EXP_W     = 17;  // Q1.16 exponent values
  localparam int unsigned RECIP_W   = 33;  // floor(2^32 / sum)
  localparam int unsigned FRAC_W    = 16;  // Q0.16 output scaling
  localparam int unsigned LUT_SHIFT = 9;
  localparam int unsigned LUT_DEPTH = 256;
  localparam int unsigned LUT_IDX_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StExp,
    StRecip,
    StNorm
  } state_e;

  typedef logic [LUT_DEPTH-1:0][EXP_W-1:0] exp_lut_t;

  // Entry j = round(65536 * exp(-j/32)): Taylor series for exp(-1/32) in Q60, then powers of it.
  function automatic exp_lut_t gen_exp_lut();
    exp_lut_t     lut;
    logic [127:0] c;
    logic [127:0] term;
    logic [127:0] e;
    term = 128'd1 << 60;
    c    = term;
    for (int n = 1; n <= 12; n++) begin
      term = term / 128'(32 * n);
      if (n[0]) c = c - term;
      else      c = c + term;
    end
    e = 128'd1 << 60;
    for (logic [8:0] j = 9'd0; j < 9'd256; j++) begin
      lut[j[7:0]] = EXP_W'((e + (128'd1 << 43)) >> 44);
      e = (e * c) >> 60;
    end
    return lut;
  endfunction

  localparam exp_lut_t EXP_LUT = gen_exp_lut();

endpackage

// File: rtl/softmax_recip_div.sv
// Restoring serial divider computing floor(2^(Q_W-1) / i_den), one quotient bit per cycle.
// o_done pulses once, Q_W cycles after the start beat; i_den must be nonzero.
module softmax_recip_div #(
  parameter int unsigned DEN_W = 22,
  parameter int unsigned Q_W   = 33
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_done,
  output logic [Q_W-1:0]   o_quot
);
  localparam int unsigned CNT_W = $clog2(Q_W);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [Q_W-1:0]   r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DEN_W:0]   w_trial;
  logic [DEN_W:0]   w_diff;
  logic             w_ge;

  // r_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign w_trial = {r_rem, r_q[Q_W-1]};
  assign w_ge    = (w_trial >= {1'b0, r_den});
  assign w_diff  = w_trial - {1'b0, r_den};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_den  <= i_den;
        r_q    <= Q_W'(1) << (Q_W - 1);
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff[DEN_W-1:0] : w_trial[DEN_W-1:0];
        r_q   <= {r_q[Q_W-2:0], w_ge};
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(Q_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_q;

endmodule

// File: rtl/softmax_stream.sv
// Streaming row softmax: buffer a row, exponentiate against the row max via LUT,
// take one serial reciprocal of the sum, then stream normalised Q0.16 results.
module softmax_stream
  import softmax_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [IN_W-1:0]    i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [$clog2(N):0] i_len,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_done
);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned SUM_W = EXP_W + IDX_W;
  localparam int unsigned BUF_W = (IN_W > EXP_W) ? IN_W : EXP_W;
  localparam int unsigned D_W   = IN_W + 1;
  localparam int unsigned P_W   = EXP_W + RECIP_W;

  state_e                 r_state;
  logic [LEN_W-1:0]       r_cnt;
  logic [LEN_W-1:0]       r_len;
  logic signed [IN_W-1:0] r_max;
  logic [SUM_W-1:0]       r_sum;
  logic [RECIP_W-1:0]     r_recip;
  logic                   r_ready;
  logic                   r_valid;
  logic                   r_done;
  logic                   r_busy;
  logic [OUT_W-1:0]       r_data;
  // Holds sign-extended inputs, then the exp values written back in place.
  logic [BUF_W-1:0]       r_buf [N];

  logic [IDX_W-1:0]       w_addr;
  logic [IDX_W-1:0]       w_nidx;
  logic                   w_accept;
  logic                   w_masked;
  logic [LEN_W-1:0]       w_len_eff;
  logic signed [IN_W-1:0] w_x;
  logic signed [D_W-1:0]  w_d;
  logic [D_W-1:0]         w_negd;
  logic [D_W-1:0]         w_shift;
  logic [LUT_IDX_W-1:0]   w_idx;
  logic [EXP_W-1:0]       w_e;
  logic                   w_buf_we;
  logic [BUF_W-1:0]       w_buf_wdata;
  logic                   w_div_start;
  logic                   w_div_done;
  logic [RECIP_W-1:0]     w_quot;

  function automatic logic [OUT_W-1:0] f_norm(input logic [EXP_W-1:0]   e,
                                              input logic [RECIP_W-1:0] r);
    logic [P_W-1:0] p;
    p = (P_W'(e) * P_W'(r)) >> FRAC_W;
    return (|p[P_W-1:OUT_W]) ? '1 : p[OUT_W-1:0];
  endfunction

  assign w_addr      = r_cnt[IDX_W-1:0];
  assign w_nidx      = w_addr + IDX_W'(1);
  assign w_accept    = i_valid & r_ready;
  assign w_len_eff   = (i_len == '0) ? LEN_W'(N) : i_len;
  assign w_masked    = (r_cnt >= r_len);
  assign w_x         = $signed(r_buf[w_addr][IN_W-1:0]);
  assign w_d         = D_W'(w_x) - D_W'(r_max);
  assign w_negd      = -w_d;
  assign w_shift     = w_negd >> LUT_SHIFT;
  assign w_idx       = (w_shift > D_W'(LUT_DEPTH - 1)) ? LUT_IDX_W'(LUT_DEPTH - 1)
                                                       : w_shift[LUT_IDX_W-1:0];
  assign w_e         = w_masked ? '0 : EXP_LUT[w_idx];
  assign w_div_start = (r_state == StExp) && (r_cnt == LEN_W'(N));

  always_comb begin
    w_buf_we    = 1'b0;
    w_buf_wdata = BUF_W'($signed(i_data));
    if (r_state == StIdle || r_state == StLoad) begin
      w_buf_we = w_accept;
    end else if (r_state == StExp) begin
      w_buf_we    = (r_cnt != LEN_W'(N));
      w_buf_wdata = BUF_W'(w_e);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_buf_we) r_buf[w_addr] <= w_buf_wdata;
  end

  softmax_recip_div #(
    .DEN_W(SUM_W),
    .Q_W  (RECIP_W)
  ) u_recip_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(w_div_start),
    .i_den  (r_sum),
    .o_done (w_div_done),
    .o_quot (w_quot)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_len   <= '0;
      r_max   <= '0;
      r_sum   <= '0;
      r_recip <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_max   <= $signed(i_data);
            r_len   <= w_len_eff;
            r_sum   <= '0;
            r_cnt   <= LEN_W'(1);
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (w_accept) begin
            if (!w_masked && ($signed(i_data) > r_max)) r_max <= $signed(i_data);
            if (r_cnt == LEN_W'(N - 1)) begin
              r_cnt   <= '0;
              r_ready <= 1'b0;
              r_state <= StExp;
            end else begin
              r_cnt <= r_cnt + LEN_W'(1);
            end
          end
        end
        StExp: begin
          if (r_cnt == LEN_W'(N)) begin
            r_state <= StRecip;
          end else begin
            r_sum <= r_sum + SUM_W'(w_e);
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        StRecip: begin
          if (w_div_done) begin
            r_recip <= w_quot;
            r_data  <= f_norm(r_buf[0][EXP_W-1:0], w_quot);
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= StNorm;
          end
        end
        StNorm: begin
          if (r_valid && i_ready) begin
            if (r_cnt == LEN_W'(N - 1)) begin
              r_valid <= 1'b0;
              r_data  <= '0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_cnt   <= '0;
              r_state <= StIdle;
            end else begin
              r_data <= f_norm(r_buf[w_nidx][EXP_W-1:0], r_recip);
              r_cnt  <= r_cnt + LEN_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_softmax_stream.sv
// Directed and randomised rows for softmax_stream, checked against a real-arithmetic
// reference of the row softmax rules (LUT from exp(), integer reciprocal and scaling).
module tb_softmax_stream;
  localparam int N     = 32;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int LEN_W = $clog2(N) + 1;
  localparam int LAT   = N + 1 + 33 + 1;

  logic             i_clk   = 1'b0;
  logic             i_rst   = 1'b1;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b0;
  logic [IN_W-1:0]  i_data  = '0;
  logic [LEN_W-1:0] i_len   = '0;
  logic             o_ready;
  logic             o_valid;
  logic             o_busy;
  logic             o_done;
  logic [OUT_W-1:0] o_data;

  int n_checks = 0;
  int n_errors = 0;
  int lut [256];
  int row_x [N];
  int row_len;
  int exp_o [N];
  int out_sum;

  softmax_stream #(
    .N    (N),
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_len  (i_len),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_reset_state();
    check("rst_o_ready", longint'(o_ready), 1);
    check("rst_o_valid", longint'(o_valid), 0);
    check("rst_o_done", longint'(o_done), 0);
    check("rst_o_busy", longint'(o_busy), 0);
    check("rst_o_data", longint'(o_data), 0);
  endtask

  // Softmax of the current row following the exp-LUT / reciprocal rules.
  task automatic build_model();
    int     eff;
    int     mx;
    int     idx;
    longint e [N];
    longint sum;
    longint r;
    longint p;
    eff = (row_len == 0) ? N : row_len;
    mx  = row_x[0];
    for (int k = 1; k < eff; k++) if (row_x[k] > mx) mx = row_x[k];
    sum = 0;
    for (int k = 0; k < N; k++) begin
      if (k >= eff) begin
        e[k] = 0;
      end else begin
        idx = (mx - row_x[k]) / 512;
        if (idx > 255) idx = 255;
        e[k] = longint'(lut[idx]);
      end
      sum += e[k];
    end
    r = (longint'(1) << 32) / sum;
    for (int k = 0; k < N; k++) begin
      p        = (e[k] * r) >> 16;
      exp_o[k] = (p > 65535) ? 65535 : int'(p);
    end
  endtask

  task automatic fill_uniform();
    for (int k = 0; k < N; k++) begin
      row_x[k] = 'h1000;
      exp_o[k] = 2048;
    end
    row_len = 0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) row_x[k] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic send_row();
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < N && guard < 10 * N) begin
      i_valid = 1'b1;
      i_data  = IN_W'(row_x[sent]);
      i_len   = LEN_W'(row_len);
      if (o_ready) sent++;
      @(posedge i_clk);
      #1;
      guard++;
    end
    i_valid = 1'b0;
    check("beats_accepted", longint'(sent), longint'(N));
  endtask

  task automatic recv_row(input bit bp);
    int         lat;
    int         k;
    int         guard;
    logic [OUT_W-1:0] held;
    logic       held_v;
    logic       rdy;
    lat = 0;
    while (!o_valid && lat < 4 * LAT) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check("latency", longint'(lat), longint'(LAT));
    check("busy_in_norm", longint'(o_busy), 1);
    check("ready_low_in_norm", longint'(o_ready), 0);
    k       = 0;
    guard   = 0;
    out_sum = 0;
    while (k < N && guard < 20 * N) begin
      rdy     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_ready = rdy;
      held    = o_data;
      held_v  = o_valid;
      @(posedge i_clk);
      #1;
      guard++;
      if (held_v && rdy) begin
        check($sformatf("o_data[%0d]", k), longint'(held), longint'(exp_o[k]));
        out_sum += int'(held);
        k++;
      end else begin
        check("stall_data", longint'(o_data), longint'(held));
        check("stall_valid", longint'(o_valid), longint'(held_v));
      end
    end
    i_ready = 1'b0;
    check("out_count", longint'(k), longint'(N));
    check("done_pulse", longint'(o_done), 1);
    check("valid_end", longint'(o_valid), 0);
    @(posedge i_clk);
    #1;
    check("done_single", longint'(o_done), 0);
    check("ready_after_done", longint'(o_ready), 1);
    check("idle_not_busy", longint'(o_busy), 0);
  endtask

  initial begin
    int dev;
    for (int j = 0; j < 256; j++) lut[j] = $rtoi($floor(65536.0 * $exp(-real'(j) / 32.0) + 0.5));

    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_reset_state();

    // Uniform row: every output 2048
    fill_uniform();
    send_row();
    recv_row(1'b0);

    // One hot element among minimum values
    for (int k = 0; k < N; k++) row_x[k] = -32768;
    row_x[5] = 32767;
    row_len  = 0;
    build_model();
    send_row();
    recv_row(1'b0);

    // Only element 0 active: saturates, rest forced to zero
    fill_random();
    row_len = 1;
    for (int k = 0; k < N; k++) exp_o[k] = (k == 0) ? 65535 : 0;
    send_row();
    recv_row(1'b0);

    // Random row with random downstream backpressure
    fill_random();
    row_len = int'($urandom_range(1, N));
    build_model();
    send_row();
    recv_row(1'b1);

    // Reset while the reciprocal is in flight, then a clean uniform row
    fill_uniform();
    send_row();
    repeat (40) @(posedge i_clk);
    #1;
    check("busy_in_recip", longint'(o_busy), 1);
    check("no_valid_in_recip", longint'(o_valid), 0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_reset_state();
    fill_uniform();
    send_row();
    recv_row(1'b0);

    // Back-to-back random rows
    for (int r = 0; r < 100; r++) begin
      fill_random();
      row_len = int'($urandom_range(0, N));
      build_model();
      send_row();
      recv_row(r % 3 == 0);
      dev = out_sum - 65536;
      if (dev < 0) dev = -dev;
      check("row_sum_within_n", longint'(dev <= N), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
